// File: rtl/sprite_rom_arbiter_pkg.sv
// Shared types and default sizing for the sprite ROM arbiter.
// Holds the arbitration state encoding and a modulo-increment helper.
package sprite_arb_pkg;

    typedef enum logic [0:0] {
        ARB = 1'b0,
        OWN = 1'b1
    } arb_state_t;

    localparam int DEF_N_REQ     = 4;
    localparam int DEF_ADDR_W    = 10;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_MAX_BURST = 32;

    // Beat counter is wide enough for the largest allowed burst (255).
    localparam int CNT_W = 8;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// Requester/ROM-side bundle of the sprite ROM arbiter.
// slave = arbiter view, master = requesters plus ROM view.
interface sprite_rom_arbiter_if
    import sprite_arb_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]             req;
    logic [N_REQ-1:0][ADDR_W-1:0] addr;
    logic [N_REQ-1:0]             gnt;
    logic [ADDR_W-1:0]            rom_address;
    logic [DATA_W-1:0]            rom_q;
    logic                         rd_valid;
    logic [ID_W-1:0]              rd_id;
    logic [DATA_W-1:0]            rd_data;

    modport slave (
        input  req,
        input  addr,
        input  rom_q,
        output gnt,
        output rom_address,
        output rd_valid,
        output rd_id,
        output rd_data
    );

    modport master (
        output req,
        output addr,
        output rom_q,
        input  gnt,
        input  rom_address,
        input  rd_valid,
        input  rd_id,
        input  rd_data
    );

endinterface

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above i_ptr,
// wrapping modulo N_REQ; returns one-hot winner, its index and an any flag.
module rr_pick
    import sprite_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    localparam int ID_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic [N_REQ-1:0] o_win_oh,
    output logic [ID_W-1:0]  o_win_idx,
    output logic             o_any
);

    int w_j;

    // Scan from farthest to nearest so the closest request to i_ptr wins last.
    always_comb begin
        o_win_oh  = '0;
        o_win_idx = '0;
        o_any     = 1'b0;
        w_j       = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_j = (int'(i_ptr) + k) % N_REQ;
            if (i_req[w_j]) begin
                o_win_oh  = N_REQ'(1) << w_j;
                o_win_idx = ID_W'(w_j);
                o_any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sprite ROM between N_REQ readers,
// with per-owner bursts of up to MAX_BURST beats and 1-cycle read return.
module sprite_rom_arbiter
    import sprite_arb_pkg::*;
#(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic                 vga_clk,
    input  logic                 reset_n,
    sprite_rom_arbiter_if.slave  bus
);

    localparam int ID_W = $clog2(N_REQ);

    arb_state_t       r_state;
    arb_state_t       w_nxt_state;
    logic [ID_W-1:0]  r_owner;
    logic [ID_W-1:0]  w_nxt_owner;
    logic [ID_W-1:0]  r_ptr;
    logic [ID_W-1:0]  w_nxt_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_nxt_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_rd_valid;
    logic [ID_W-1:0]  r_rd_id;

    logic [ID_W-1:0]   w_owner_inc;
    logic [ID_W-1:0]   w_win_inc;
    logic [ID_W-1:0]   w_pick_ptr;
    logic [N_REQ-1:0]  w_owner_oh;
    logic [N_REQ-1:0]  w_win_oh;
    logic [ID_W-1:0]   w_win_idx;
    logic              w_win_any;
    logic [N_REQ-1:0]  w_gnt;
    logic [ID_W-1:0]   w_gnt_idx;
    logic [ADDR_W-1:0] w_rom_addr;

    always_comb begin
        w_owner_oh  = N_REQ'(1) << r_owner;
        w_owner_inc = ID_W'(wrap_inc(int'(r_owner), N_REQ));
        w_cnt_inc   = r_cnt + CNT_W'(1);
    end

    // When the owner lets go, arbitration resumes just past it so it cannot
    // jump ahead of requesters that were already waiting.
    assign w_pick_ptr = (r_state == OWN) ? w_owner_inc : r_ptr;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .i_req     (bus.req),
        .i_ptr     (w_pick_ptr),
        .o_win_oh  (w_win_oh),
        .o_win_idx (w_win_idx),
        .o_any     (w_win_any)
    );

    assign w_win_inc = ID_W'(wrap_inc(int'(w_win_idx), N_REQ));

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_owner = r_owner;
        w_nxt_ptr   = r_ptr;
        w_nxt_cnt   = r_cnt;
        w_gnt       = '0;
        w_gnt_idx   = r_owner;

        unique case (r_state)
            ARB: begin
                if (w_win_any) begin
                    w_gnt     = w_win_oh;
                    w_gnt_idx = w_win_idx;
                    if (MAX_BURST == 1) begin
                        w_nxt_ptr = w_win_inc;
                    end else begin
                        w_nxt_state = OWN;
                        w_nxt_owner = w_win_idx;
                        w_nxt_cnt   = CNT_W'(1);
                    end
                end
            end
            OWN: begin
                if (bus.req[r_owner]) begin
                    w_gnt     = w_owner_oh;
                    w_gnt_idx = r_owner;
                    w_nxt_cnt = w_cnt_inc;
                    if (w_cnt_inc == CNT_W'(MAX_BURST)) begin
                        w_nxt_state = ARB;
                        w_nxt_ptr   = w_owner_inc;
                        w_nxt_cnt   = '0;
                    end
                end else begin
                    w_nxt_ptr = w_owner_inc;
                    if (w_win_any) begin
                        w_gnt       = w_win_oh;
                        w_gnt_idx   = w_win_idx;
                        w_nxt_owner = w_win_idx;
                        w_nxt_cnt   = CNT_W'(1);
                    end else begin
                        w_nxt_state = ARB;
                        w_nxt_cnt   = '0;
                    end
                end
            end
            default: begin
                w_nxt_state = ARB;
            end
        endcase

        // Outputs are squelched for the whole reset window, not just at the edge.
        if (!reset_n) begin
            w_gnt = '0;
        end
    end

    always_comb begin
        w_rom_addr = '0;
        if (|w_gnt) begin
            w_rom_addr = bus.addr[w_gnt_idx];
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ARB;
            r_owner    <= '0;
            r_ptr      <= '0;
            r_cnt      <= '0;
            r_rd_valid <= 1'b0;
            r_rd_id    <= '0;
        end else begin
            r_state    <= w_nxt_state;
            r_owner    <= w_nxt_owner;
            r_ptr      <= w_nxt_ptr;
            r_cnt      <= w_nxt_cnt;
            r_rd_valid <= |w_gnt;
            if (|w_gnt) begin
                r_rd_id <= w_gnt_idx;
            end
        end
    end

    assign bus.gnt         = w_gnt;
    assign bus.rom_address = w_rom_addr;
    assign bus.rd_valid    = r_rd_valid;
    assign bus.rd_id       = r_rd_id;
    assign bus.rd_data     = bus.rom_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed-vector bench for sprite_rom_arbiter (N_REQ=4, MAX_BURST=4) with a
// synchronous ROM model; table rows plus a sustained all-request sequence.
module tb_sprite_rom_arbiter;

    localparam int N  = 4;
    localparam int AW = 10;
    localparam int DW = 8;
    localparam int MB = 4;

    localparam logic [AW-1:0] A0 = 10'h100;
    localparam logic [AW-1:0] A1 = 10'h211;
    localparam logic [AW-1:0] A2 = 10'h05A;
    localparam logic [AW-1:0] A3 = 10'h3C3;

    logic vga_clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    sprite_rom_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    sprite_rom_arbiter #(
        .N_REQ     (N),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .MAX_BURST (MB)
    ) dut (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 vga_clk = ~vga_clk;

    function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
        return a[7:0] ^ {a[9:8], 6'h15};
    endfunction

    always @(posedge vga_clk) bus.rom_q <= rom_f(bus.rom_address);

    typedef struct {
        logic          rst_n;
        logic [N-1:0]  req;
        logic [N-1:0]  gnt;
        logic [AW-1:0] addr;
        logic          vld;
        logic [1:0]    id;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst_n, input logic [N-1:0] req, input logic [N-1:0] gnt,
                       input logic [AW-1:0] addr, input logic vld, input logic [1:0] id);
        vec_t v;
        v.rst_n = rst_n; v.req = req; v.gnt = gnt; v.addr = addr; v.vld = vld; v.id = id;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        int exp_id;
        int prev_id;

        bus.req     = '0;
        bus.addr[0] = A0;
        bus.addr[1] = A1;
        bus.addr[2] = A2;
        bus.addr[3] = A3;

        //   rst   req      gnt      addr   vld   id
        add(1'b0, 4'b0000, 4'b0000, 10'h0, 1'b0, 2'd0); // 0 in reset
        add(1'b1, 4'b0000, 4'b0000, 10'h0, 1'b0, 2'd0); // 1 idle
        add(1'b1, 4'b0100, 4'b0100, A2,    1'b0, 2'd0); // 2 single requester
        add(1'b1, 4'b0100, 4'b0100, A2,    1'b1, 2'd2); // 3
        add(1'b1, 4'b0100, 4'b0100, A2,    1'b1, 2'd2); // 4
        add(1'b1, 4'b0000, 4'b0000, 10'h0, 1'b1, 2'd2); // 5 -> ptr=3
        add(1'b1, 4'b0000, 4'b0000, 10'h0, 1'b0, 2'd0); // 6 idle, no valid
        add(1'b1, 4'b1001, 4'b1000, A3,    1'b0, 2'd0); // 7 wrap: 3 first
        add(1'b1, 4'b0001, 4'b0001, A0,    1'b1, 2'd3); // 8 then 0
        add(1'b1, 4'b0011, 4'b0001, A0,    1'b1, 2'd0); // 9 burst of 4 for req0
        add(1'b1, 4'b0011, 4'b0001, A0,    1'b1, 2'd0); // 10
        add(1'b1, 4'b0011, 4'b0001, A0,    1'b1, 2'd0); // 11 beat 4
        add(1'b1, 4'b0011, 4'b0010, A1,    1'b1, 2'd0); // 12 req1 takes over
        add(1'b1, 4'b0011, 4'b0010, A1,    1'b1, 2'd1); // 13
        add(1'b1, 4'b0011, 4'b0010, A1,    1'b1, 2'd1); // 14
        add(1'b1, 4'b0011, 4'b0010, A1,    1'b1, 2'd1); // 15 beat 4
        add(1'b1, 4'b0011, 4'b0001, A0,    1'b1, 2'd1); // 16 back to req0
        add(1'b1, 4'b1010, 4'b0010, A1,    1'b1, 2'd0); // 17 req0 drops
        add(1'b1, 4'b1010, 4'b0010, A1,    1'b1, 2'd1); // 18 req1 beat 2
        add(1'b1, 4'b1000, 4'b1000, A3,    1'b1, 2'd1); // 19 early release, no gap
        add(1'b1, 4'b1010, 4'b1000, A3,    1'b1, 2'd3); // 20 req1 back, owner keeps
        add(1'b1, 4'b0011, 4'b0001, A0,    1'b1, 2'd3); // 21
        add(1'b1, 4'b0010, 4'b0010, A1,    1'b1, 2'd0); // 22
        add(1'b1, 4'b0000, 4'b0000, 10'h0, 1'b1, 2'd1); // 23 -> ptr=2
        add(1'b1, 4'b0000, 4'b0000, 10'h0, 1'b0, 2'd0); // 24
        add(1'b1, 4'b0100, 4'b0100, A2,    1'b0, 2'd0); // 25 req2 beat 1
        add(1'b1, 4'b0100, 4'b0100, A2,    1'b1, 2'd2); // 26
        add(1'b1, 4'b0100, 4'b0100, A2,    1'b1, 2'd2); // 27
        add(1'b1, 4'b0100, 4'b0100, A2,    1'b1, 2'd2); // 28
        add(1'b0, 4'b0100, 4'b0000, 10'h0, 1'b0, 2'd0); // 29 reset at beat 5
        add(1'b1, 4'b1111, 4'b0001, A0,    1'b0, 2'd0); // 30 restart from ptr 0
        add(1'b1, 4'b0000, 4'b0000, 10'h0, 1'b1, 2'd0); // 31 -> ptr=1
        add(1'b1, 4'b0000, 4'b0000, 10'h0, 1'b0, 2'd0); // 32

        for (int r = 0; r < vecs.size(); r++) begin
            @(negedge vga_clk);
            reset_n = vecs[r].rst_n;
            bus.req = vecs[r].req;
            #1;
            chk($sformatf("row%0d gnt", r), 32'(bus.gnt), 32'(vecs[r].gnt));
            chk($sformatf("row%0d rom_address", r), 32'(bus.rom_address), 32'(vecs[r].addr));
            chk($sformatf("row%0d rd_valid", r), 32'(bus.rd_valid), 32'(vecs[r].vld));
            if (vecs[r].vld || !vecs[r].rst_n)
                chk($sformatf("row%0d rd_id", r), 32'(bus.rd_id), 32'(vecs[r].id));
            if (vecs[r].vld && r > 0)
                chk($sformatf("row%0d rd_data", r), 32'(bus.rd_data), 32'(rom_f(vecs[r-1].addr)));
        end

        // Saturated load from ptr=1: bursts of MB rotate 1,2,3,0 with a beat every cycle.
        prev_id = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge vga_clk);
            bus.req = 4'b1111;
            #1;
            exp_id = (1 + k / MB) % N;
            chk($sformatf("sat%0d gnt", k), 32'(bus.gnt), 32'(1) << exp_id);
            if (k > 0) begin
                chk($sformatf("sat%0d rd_valid", k), 32'(bus.rd_valid), 32'd1);
                chk($sformatf("sat%0d rd_id", k), 32'(bus.rd_id), 32'(prev_id));
            end
            prev_id = exp_id;
        end

        @(negedge vga_clk);
        bus.req = '0;
        #1;
        chk("drain gnt", 32'(bus.gnt), 32'd0);
        chk("drain rd_id", 32'(bus.rd_id), 32'(prev_id));
        @(negedge vga_clk);
        #1;
        chk("drain rd_valid", 32'(bus.rd_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
